wifi_frame_builder: RTL and testbench

Parametrised successor to the fixed-rate 802.11a transmit framer. Builds a complete PLCP frame bit-serially: preamble, SIGNAL field, then the scrambled DATA field (SERVICE, PSDU, tail, pad). Differences from the fixed framer:
- Rate and length are runtime inputs, latched on Start.
- N_DBPS is derived per rate.
- PSDU input uses a valid/ready handshake with stall support.
- Scrambled tail bits are forced to zero.
- Output carries a qualifying valid strobe.
- Illegal requests are rejected with an error pulse.
Sits between the MAC byte serializer and the convolutional encoder.

---
 rtl/wifi_frame_builder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_wifi_frame_builder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wifi_frame_builder.sv
// wifi_frame_builder
//
// Bit-serial 802.11a PLCP framer. Emits the preamble, the unscrambled SIGNAL
// field, then the scrambled DATA field (SERVICE, PSDU, tail, pad) for a
// runtime-selected rate and PSDU length.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset, aborts any frame
//   i_start        one-cycle frame request, sampled only in IDLE
//   i_rate         SIGNAL RATE code, i_rate[3] is R1
//   i_length       PSDU length in octets
//   i_data_in      PSDU bit, LSB of each octet first
//   i_data_valid   i_data_in is valid this cycle
//   o_data_ready   a PSDU bit is consumed when this and i_data_valid are high
//   o_out_bit      frame bit
//   o_out_valid    o_out_bit is valid
//   o_busy         frame in progress
//   o_done         pulse on the cycle the final frame bit is output
//   o_error        pulse after a rejected start request
module wifi_frame_builder #(
    parameter int unsigned PREAMBLE_BITS    = 96,
    parameter logic [7:0]  PREAMBLE_PATTERN = 8'hAA,
    parameter logic [6:0]  SCRAMBLER_SEED   = 7'h5D,
    parameter bit          ZERO_TAIL        = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [3:0]  i_rate,
    input  logic [11:0] i_length,
    input  logic        i_data_in,
    input  logic        i_data_valid,
    output logic        o_data_ready,
    output logic        o_out_bit,
    output logic        o_out_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [3:0] {
        StIdle, StPreamble, StSigRate, StSigRsvd, StSigLen, StSigPar, StSigTail,
        StService, StPsdu, StDtail, StPad
    } state_e;

    state_e      r_state,    w_state;
    logic [3:0]  r_rate,     w_rate;
    logic [11:0] r_length,   w_length;
    logic [7:0]  r_ndbps,    w_ndbps;
    logic [7:0]  r_cnt,      w_cnt;       // preamble / small-field bit index
    logic [14:0] r_psdu_cnt, w_psdu_cnt;  // PSDU bits consumed
    logic [7:0]  r_sym_cnt,  w_sym_cnt;   // DATA bits modulo N_DBPS
    logic [6:0]  r_scr,      w_scr;       // r_scr[6] = s7 ... r_scr[0] = s1
    logic        r_out_bit,  w_out_bit;
    logic        r_out_valid, w_out_valid;
    logic        r_busy,     w_busy;
    logic        r_done,     w_done;
    logic        r_error,    w_error;

    logic        w_fb;
    logic [6:0]  w_scr_adv;
    logic [14:0] w_psdu_bits;
    logic        w_sym_last;
    logic [7:0]  w_sym_inc;
    logic [7:0]  w_req_ndbps;
    logic        w_req_legal;

    assign w_fb        = r_scr[6] ^ r_scr[3];
    assign w_scr_adv   = {r_scr[5:0], w_fb};
    assign w_psdu_bits = {r_length, 3'b000};
    assign w_sym_last  = (r_sym_cnt == r_ndbps - 8'd1);
    assign w_sym_inc   = w_sym_last ? 8'd0 : r_sym_cnt + 8'd1;

    assign o_data_ready = (r_state == StPsdu) && (r_psdu_cnt < w_psdu_bits);
    assign o_out_bit    = r_out_bit;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

    always_comb begin
        w_req_ndbps = 8'd0;
        w_req_legal = 1'b1;
        case (i_rate)
            4'b1101: w_req_ndbps = 8'd24;
            4'b1111: w_req_ndbps = 8'd36;
            4'b0101: w_req_ndbps = 8'd48;
            4'b0111: w_req_ndbps = 8'd72;
            4'b1001: w_req_ndbps = 8'd96;
            4'b1011: w_req_ndbps = 8'd144;
            4'b0001: w_req_ndbps = 8'd192;
            4'b0011: w_req_ndbps = 8'd216;
            default: w_req_legal = 1'b0;
        endcase
    end

    // Each state names the field whose next bit is produced at the coming edge;
    // the accepting edge in IDLE produces preamble bit 0 itself.
    always_comb begin
        w_state     = r_state;
        w_rate      = r_rate;
        w_length    = r_length;
        w_ndbps     = r_ndbps;
        w_cnt       = r_cnt;
        w_psdu_cnt  = r_psdu_cnt;
        w_sym_cnt   = r_sym_cnt;
        w_scr       = r_scr;
        w_out_bit   = 1'b0;
        w_out_valid = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (!w_req_legal || (i_length == 12'd0)) begin
                        w_error = 1'b1;
                    end else begin
                        w_rate      = i_rate;
                        w_length    = i_length;
                        w_ndbps     = w_req_ndbps;
                        w_state     = StPreamble;
                        w_out_bit   = PREAMBLE_PATTERN[7];
                        w_out_valid = 1'b1;
                        w_cnt       = 8'd1;
                    end
                end
            end
            StPreamble: begin
                w_out_bit   = PREAMBLE_PATTERN[3'd7 - r_cnt[2:0]];
                w_out_valid = 1'b1;
                w_cnt       = r_cnt + 8'd1;
                if (r_cnt == 8'(PREAMBLE_BITS - 1)) begin
                    w_state = StSigRate;
                    w_cnt   = 8'd0;
                end
            end
            StSigRate: begin
                w_out_bit   = r_rate[2'd3 - r_cnt[1:0]];
                w_out_valid = 1'b1;
                w_cnt       = r_cnt + 8'd1;
                if (r_cnt == 8'd3) begin
                    w_state = StSigRsvd;
                    w_cnt   = 8'd0;
                end
            end
            StSigRsvd: begin
                w_out_valid = 1'b1;
                w_state     = StSigLen;
            end
            StSigLen: begin
                w_out_bit   = r_length[r_cnt[3:0]];
                w_out_valid = 1'b1;
                w_cnt       = r_cnt + 8'd1;
                if (r_cnt == 8'd11) begin
                    w_state = StSigPar;
                    w_cnt   = 8'd0;
                end
            end
            StSigPar: begin
                w_out_bit   = (^r_rate) ^ (^r_length);
                w_out_valid = 1'b1;
                w_state     = StSigTail;
            end
            StSigTail: begin
                w_out_valid = 1'b1;
                w_cnt       = r_cnt + 8'd1;
                if (r_cnt == 8'd5) begin
                    w_state   = StService;
                    w_cnt     = 8'd0;
                    w_scr     = SCRAMBLER_SEED;
                    w_sym_cnt = 8'd0;
                end
            end
            StService: begin
                w_out_bit   = w_fb;
                w_out_valid = 1'b1;
                w_scr       = w_scr_adv;
                w_sym_cnt   = w_sym_inc;
                w_cnt       = r_cnt + 8'd1;
                if (r_cnt == 8'd15) begin
                    w_state    = StPsdu;
                    w_cnt      = 8'd0;
                    w_psdu_cnt = 15'd0;
                end
            end
            StPsdu: begin
                // Stalled cycles leave scrambler and counters untouched.
                if (i_data_valid && o_data_ready) begin
                    w_out_bit   = i_data_in ^ w_fb;
                    w_out_valid = 1'b1;
                    w_scr       = w_scr_adv;
                    w_sym_cnt   = w_sym_inc;
                    w_psdu_cnt  = r_psdu_cnt + 15'd1;
                    if (r_psdu_cnt == w_psdu_bits - 15'd1) begin
                        w_state = StDtail;
                        w_cnt   = 8'd0;
                    end
                end
            end
            StDtail: begin
                w_out_bit   = ZERO_TAIL ? 1'b0 : w_fb;
                w_out_valid = 1'b1;
                w_scr       = w_scr_adv;
                w_sym_cnt   = w_sym_inc;
                w_cnt       = r_cnt + 8'd1;
                if (r_cnt == 8'd5) begin
                    w_cnt = 8'd0;
                    if (w_sym_last) begin
                        w_state = StIdle;
                        w_done  = 1'b1;
                    end else begin
                        w_state = StPad;
                    end
                end
            end
            StPad: begin
                w_out_bit   = w_fb;
                w_out_valid = 1'b1;
                w_scr       = w_scr_adv;
                w_sym_cnt   = w_sym_inc;
                if (w_sym_last) begin
                    w_state = StIdle;
                    w_done  = 1'b1;
                end
            end
            default: w_state = StIdle;
        endcase
        w_busy = (w_state != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_rate      <= 4'd0;
            r_length    <= 12'd0;
            r_ndbps     <= 8'd0;
            r_cnt       <= 8'd0;
            r_psdu_cnt  <= 15'd0;
            r_sym_cnt   <= 8'd0;
            r_scr       <= SCRAMBLER_SEED;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_rate      <= w_rate;
            r_length    <= w_length;
            r_ndbps     <= w_ndbps;
            r_cnt       <= w_cnt;
            r_psdu_cnt  <= w_psdu_cnt;
            r_sym_cnt   <= w_sym_cnt;
            r_scr       <= w_scr;
            r_out_bit   <= w_out_bit;
            r_out_valid <= w_out_valid;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_error     <= w_error;
        end
    end

endmodule

// File: tb/tb_wifi_frame_builder.sv
// tb_wifi_frame_builder
//
// Drives two framers in parallel (default seed with zeroed tail, and seed
// 7'h7F with scrambled tail). Expected frame bits are queued when a frame is
// started and popped as the DUTs raise OutValid.
module tb_wifi_frame_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  rate = 4'd0;
    logic [11:0] len = 12'd0;
    logic        data_in = 1'b0;
    logic        data_valid = 1'b0;

    logic a_ready, a_bit, a_valid, a_busy, a_done, a_error;
    logic b_ready, b_bit, b_valid, b_busy, b_done, b_error;

    wifi_frame_builder u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_rate(rate), .i_length(len),
        .i_data_in(data_in), .i_data_valid(data_valid), .o_data_ready(a_ready),
        .o_out_bit(a_bit), .o_out_valid(a_valid), .o_busy(a_busy), .o_done(a_done),
        .o_error(a_error)
    );

    wifi_frame_builder #(
        .PREAMBLE_BITS(96), .PREAMBLE_PATTERN(8'hAA), .SCRAMBLER_SEED(7'h7F),
        .ZERO_TAIL(1'b0)
    ) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_rate(rate), .i_length(len),
        .i_data_in(data_in), .i_data_valid(data_valid), .o_data_ready(b_ready),
        .o_out_bit(b_bit), .o_out_valid(b_valid), .o_busy(b_busy), .o_done(b_done),
        .o_error(b_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    bit exp_a[$];
    bit exp_b[$];
    bit pay_bits[$];
    int pidx;
    int nval_a, nval_b, done_a, done_b, err_a, idx_b;
    logic [15:0] svc_b;
    logic [3:0]  dv_pat = 4'b1001;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ndbps(input logic [3:0] r);
        case (r)
            4'b1101: return 24;
            4'b1111: return 36;
            4'b0101: return 48;
            4'b0111: return 72;
            4'b1001: return 96;
            4'b1011: return 144;
            4'b0001: return 192;
            4'b0011: return 216;
            default: return 0;
        endcase
    endfunction

    task automatic push_frame(input logic [3:0] r, input logic [11:0] l,
                              input logic [6:0] seed, input bit zt, input bit to_b);
        bit q[$];
        logic [7:0] pat = 8'hAA;
        logic [6:0] s = seed;
        bit fb, ib, ob;
        int nd, d, pad, nb;
        for (int i = 0; i < 96; i++) q.push_back(pat[7 - (i % 8)]);
        for (int i = 3; i >= 0; i--) q.push_back(r[i]);
        q.push_back(1'b0);
        for (int i = 0; i < 12; i++) q.push_back(l[i]);
        q.push_back((^r) ^ (^l));
        for (int i = 0; i < 6; i++) q.push_back(1'b0);
        nb  = 8 * int'(l);
        nd  = ndbps(r);
        d   = 22 + nb;
        pad = (nd - d % nd) % nd;
        for (int i = 0; i < d + pad; i++) begin
            ib = (i >= 16 && i < 16 + nb) ? pay_bits[i - 16] : 1'b0;
            fb = s[6] ^ s[3];
            s  = {s[5:0], fb};
            ob = ib ^ fb;
            if (zt && i >= 16 + nb && i < d) ob = 1'b0;
            q.push_back(ob);
        end
        foreach (q[i]) begin
            if (to_b) exp_b.push_back(q[i]);
            else      exp_a.push_back(q[i]);
        end
    endtask

    task automatic monitor();
        bit prev_ok = 1'b0;
        bit prev_dv = 1'b0;
        bit eb;
        forever begin
            @(negedge clk);
            if (a_valid) begin
                nval_a++;
                if (exp_a.size() == 0) chk("extra_bit_a", 1, 0);
                else begin eb = exp_a.pop_front(); chk("bit_a", a_bit, eb); end
            end
            if (b_valid) begin
                nval_b++;
                if (idx_b >= 120 && idx_b < 136) svc_b = {svc_b[14:0], b_bit};
                idx_b++;
                if (exp_b.size() == 0) chk("extra_bit_b", 1, 0);
                else begin eb = exp_b.pop_front(); chk("bit_b", b_bit, eb); end
            end
            if (a_done) begin
                done_a++;
                chk("busy_at_done_a", a_busy, 0);
                chk("done_on_last_a", exp_a.size(), 0);
            end
            if (b_done) begin
                done_b++;
                chk("done_on_last_b", exp_b.size(), 0);
            end
            if (a_error) err_a++;
            if (prev_ok) chk("stall_gap", a_valid, prev_dv);
            prev_ok = a_ready && !rst;
            prev_dv = data_valid;
        end
    endtask

    // Called at #1 after a rising edge.
    task automatic start_frame(input logic [3:0] r, input logic [11:0] l, input bit newpay);
        logic [7:0] byt;
        if (newpay) begin
            pay_bits.delete();
            for (int i = 0; i < int'(l); i++) begin
                byt = 8'($urandom_range(0, 255));
                for (int j = 0; j < 8; j++) pay_bits.push_back(byt[j]);
            end
        end
        push_frame(r, l, 7'h5D, 1'b1, 1'b0);
        push_frame(r, l, 7'h7F, 1'b0, 1'b1);
        nval_a = 0; nval_b = 0; done_a = 0; done_b = 0; err_a = 0; idx_b = 0; svc_b = 16'd0;
        pidx = 0;
        data_in = pay_bits[0];
        data_valid = 1'b1;
        start = 1'b1; rate = r; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", a_busy, 1);
        chk("first_valid", a_valid, 1);
    endtask

    task automatic drive_step(input bit stall, inout int k);
        bit fire;
        fire = a_ready && data_valid;
        @(posedge clk); #1;
        if (fire) pidx++;
        data_in = (pidx < pay_bits.size()) ? pay_bits[pidx] : 1'b0;
        data_valid = stall ? dv_pat[k % 4] : 1'b1;
        k++;
    endtask

    task automatic wait_done(input bit stall, input bit poke_mid, input bit poke_last,
                             input int n_exp);
        bit seen = 1'b0;
        int k = 0;
        int cyc = 0;
        while (!seen && cyc < 2000) begin
            drive_step(stall, k);
            cyc++;
            start = 1'b0;
            if (poke_mid && cyc == 40) begin start = 1'b1; rate = 4'b0000; end
            if (poke_last && exp_a.size() == 2) begin start = 1'b1; rate = 4'b1101; len = 12'd1; end
            if (a_done) seen = 1'b1;
        end
        if (!seen) chk("timeout", 0, 1);
        start = 1'b0;
        @(posedge clk); #1;
        if (poke_last) begin
            chk("start_at_done_busy", a_busy, 0);
            chk("start_at_done_valid", a_valid, 0);
        end
        chk("nvalid_a", nval_a, n_exp);
        chk("nvalid_b", nval_b, n_exp);
        chk("done_once_a", done_a, 1);
        chk("done_once_b", done_b, 1);
        chk("no_err_in_frame", err_a, 0);
        chk("svc_b", svc_b, 16'h0EF2);
        chk("queue_empty_a", exp_a.size(), 0);
        chk("queue_empty_b", exp_b.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, a_valid, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_error"}, a_error, 0);
        chk({tag, "_ready"}, a_ready, 0);
        chk({tag, "_bit"}, a_bit, 0);
        chk({tag, "_valid_b"}, b_valid, 0);
    endtask

    task automatic reject(input logic [3:0] r, input logic [11:0] l, input string tag);
        start = 1'b1; rate = r; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_error"}, a_error, 1);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_valid"}, a_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_error_clr"}, a_error, 0);
        chk({tag, "_busy2"}, a_busy, 0);
        chk({tag, "_valid2"}, a_valid, 0);
    endtask

    task automatic run_tests();
        int k = 0;
        int cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        start_frame(4'b1101, 12'd16, 1'b1);
        wait_done(1'b0, 1'b1, 1'b0, 288);
        start_frame(4'b0011, 12'd1, 1'b1);
        wait_done(1'b0, 1'b0, 1'b1, 336);
        start_frame(4'b1101, 12'd16, 1'b1);
        wait_done(1'b1, 1'b0, 1'b0, 288);
        start_frame(4'b1111, 12'd2, 1'b1);
        wait_done(1'b0, 1'b0, 1'b0, 192);
        start_frame(4'b1001, 12'd3, 1'b1);
        wait_done(1'b1, 1'b0, 1'b0, 216);

        reject(4'b0000, 12'd5, "bad_rate");
        reject(4'b1101, 12'd0, "zero_len");

        start_frame(4'b1101, 12'd4, 1'b1);
        while (pidx < 5 && cyc < 400) begin
            drive_step(1'b0, k);
            cyc++;
        end
        chk("reached_psdu", (pidx >= 5) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        exp_a.delete();
        exp_b.delete();
        start_frame(4'b1101, 12'd2, 1'b1);
        wait_done(1'b0, 1'b0, 1'b0, 168);
    endtask

    initial begin
        fork
            monitor();
            run_tests();
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
